mem_arbiter_n: RTL and testbench

Parametrised N-channel memory arbiter. It replaces the fixed two-client (fetch + load/store) memory controller between the CPU front-end/LSU and the single-cycle-latency RAM/IO port. Any number of requesters share one read/write memory port. Arbitration is either fixed-priority or round-robin. The datapath is pipelined to sustain one transaction every 2 cycles.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_n_if.sv | 33 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/mem_arbiter_n.sv | 120 ++++++++++++
 tb/tb_mem_arbiter_n.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the N-channel memory arbiter.
//   ARB_FIXED / ARB_RR : values of the ARB_MODE parameter
//   arb_state_t        : arbiter FSM state encoding
//   idx_w()            : width of a channel index for a given channel count
package mem_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,   // nothing in flight, arbitrate
    ST_ISSUE = 2'd1,   // memory access presented this cycle
    ST_RESP  = 2'd2    // memory data on mem_data, complete and maybe re-arbitrate
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_n_if.sv
// Requester + memory bus of the N-channel memory arbiter.
//   req_valid/req_we/req_addr/req_wdata : per-channel request, held until req_done
//   req_done/req_rdata                  : per-channel completion pulse and read data
//   mem_addr/mem_wr/mem_src             : registered memory command
//   mem_data                            : memory read data, one cycle after mem_addr
// Channel i of a packed per-channel field sits at [i*WIDTH +: WIDTH].
// Modports: slave = the arbiter, master = the requesters and the memory.
interface mem_arbiter_n_if #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_CH-1:0]                 req_valid;
  logic [NUM_CH-1:0]                 req_we;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] req_wdata;
  logic [NUM_CH-1:0]                 req_done;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] req_rdata;
  logic [ADDR_WIDTH-1:0]             mem_addr;
  logic                              mem_wr;
  logic [DATA_WIDTH-1:0]             mem_src;
  logic [DATA_WIDTH-1:0]             mem_data;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_data,
    output req_done, req_rdata, mem_addr, mem_wr, mem_src
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_data,
    input  req_done, req_rdata, mem_addr, mem_wr, mem_src
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational grant selection for the memory arbiter.
//   elig : eligible channels
//   mode : 0 = fixed priority (channel 0 highest), 1 = round-robin
//   last : last granted channel; round-robin search starts at last+1
//   gnt  : one-hot grant, idx : encoded grant, any : some channel granted
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] elig,
  input  logic              mode,
  input  logic [IDX_W-1:0]  last,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  int               pos;
  logic [IDX_W-1:0] cand;

  // Walk the channels in priority order; the first eligible one wins.
  // Round-robin rotates the order so it begins just after the last grant.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    pos  = 0;
    cand = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pos  = mode ? (int'(last) + 1 + k) % NUM_CH : k;
      cand = IDX_W'(pos);
      if (!any && elig[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-channel memory arbiter: shares one single-cycle-latency RAM/IO port
// between NUM_CH requesters, one transaction every 2 cycles at best.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester + memory bus (slave modport)
// Timing for a grant taken at the edge ending cycle n:
//   n+1 mem_addr/mem_wr/mem_src valid (ISSUE)
//   n+2 mem_data sampled at the closing edge (RESP)
//   n+3 req_done[g] pulse with req_rdata[g]
module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = ARB_FIXED
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_n_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_CH);

  arb_state_t       state;
  logic [IDX_W-1:0] last;     // last granted channel (round-robin pointer)
  logic [IDX_W-1:0] cur;      // channel in flight
  logic             cur_we;   // in-flight access is a write

  logic [NUM_CH-1:0]     inflight;
  logic [NUM_CH-1:0]     elig;
  logic [NUM_CH-1:0]     gnt;
  logic [IDX_W-1:0]      g;
  logic                  any;
  logic                  take;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_we;

  // During RESP the channel being completed still holds req_valid but has
  // not seen its done pulse yet; mask it so it is not served twice. In the
  // following cycle the done pulse itself does the masking.
  always_comb begin
    inflight = '0;
    if (state == ST_RESP) inflight[cur] = 1'b1;
  end

  assign elig = bus.req_valid & ~bus.req_done & ~inflight;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .elig (elig),
    .mode (1'(ARB_MODE == ARB_RR)),
    .last (last),
    .gnt  (gnt),
    .idx  (g),
    .any  (any)
  );

  // One-hot AND-OR select of the granted request fields.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_addr  = sel_addr  | bus.req_addr[i];
        sel_wdata = sel_wdata | bus.req_wdata[i];
        sel_we    = sel_we    | bus.req_we[i];
      end
    end
  end

  // A new access can start from IDLE or overlap the RESP of the previous one.
  assign take = any && (state != ST_ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      last          <= IDX_W'(NUM_CH - 1);
      cur           <= '0;
      cur_we        <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wr    <= 1'b0;
      bus.mem_src   <= '0;
      bus.req_done  <= '0;
      bus.req_rdata <= '0;
    end else begin
      bus.req_done <= '0;

      if (take) begin
        bus.mem_addr <= sel_addr;
        bus.mem_wr   <= sel_we;
        bus.mem_src  <= sel_wdata;
        cur          <= g;
        cur_we       <= sel_we;
        last         <= g;
      end else begin
        bus.mem_wr   <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          if (take) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (!cur_we) bus.req_rdata[cur] <= bus.mem_data;
          bus.req_done[cur] <= 1'b1;
          state <= take ? ST_ISSUE : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
module tb_mem_arbiter_n;
  import mem_arb_pkg::*;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_n_if #(.NUM_CH(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_fix ();
  mem_arbiter_n_if #(.NUM_CH(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_rr ();

  mem_arbiter_n #(.NUM_CH(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(ARB_FIXED))
    u_fix (.clk(clk), .rst(rst), .bus(if_fix));
  mem_arbiter_n #(.NUM_CH(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(ARB_RR))
    u_rr (.clk(clk), .rst(rst), .bus(if_rr));

  // stimulus, steered to the DUT under test (sel: 0 fixed, 1 round-robin)
  logic                  sel = 1'b0;
  logic [NC-1:0]         vld = '0;
  logic [NC-1:0]         we  = '0;
  logic [NC-1:0][AW-1:0] addr  = '0;
  logic [NC-1:0][DW-1:0] wdata = '0;
  logic [DW-1:0]         mdata = '0;

  assign if_fix.req_valid = sel ? '0 : vld;
  assign if_rr.req_valid  = sel ? vld : '0;
  assign if_fix.req_we    = we;
  assign if_rr.req_we     = we;
  assign if_fix.req_addr  = addr;
  assign if_rr.req_addr   = addr;
  assign if_fix.req_wdata = wdata;
  assign if_rr.req_wdata  = wdata;
  assign if_fix.mem_data  = mdata;
  assign if_rr.mem_data   = mdata;

  logic [NC-1:0]         o_done;
  logic [NC-1:0][DW-1:0] o_rdata;
  logic [AW-1:0]         o_maddr;
  logic                  o_mwr;
  logic [DW-1:0]         o_msrc;
  assign o_done  = sel ? if_rr.req_done  : if_fix.req_done;
  assign o_rdata = sel ? if_rr.req_rdata : if_fix.req_rdata;
  assign o_maddr = sel ? if_rr.mem_addr  : if_fix.mem_addr;
  assign o_mwr   = sel ? if_rr.mem_wr    : if_fix.mem_wr;
  assign o_msrc  = sel ? if_rr.mem_src   : if_fix.mem_src;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // memory contents before any write
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A);
  endfunction

  // memory responder and the reference model's own view of memory
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [AW-1:0] prv_addr = '0;
  logic          prv_wr   = 1'b0;
  logic [DW-1:0] prv_src  = '0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // done events seen on the DUT
  typedef struct { int t; int ch; logic [31:0] d; } dev_t;
  dev_t dlog[$];
  logic [NC-1:0] seen_done = '0;

  // ---------------- reference model (transaction/time level) ----------------
  // A grant at cycle t books the port until t+2, shows mem_* in t+1 and the
  // done pulse with data in t+3. A channel is a candidate when valid, not
  // showing done, and not already booked.
  bit            armed = 1'b0;
  int            sched_t [NC];
  logic          sched_we [NC];
  logic [DW-1:0] sched_val [NC];
  logic [DW-1:0] exp_rd [NC];
  int            ev_t = -1;
  logic [AW-1:0] ev_addr;
  logic [DW-1:0] ev_src;
  logic          ev_wr;
  logic [AW-1:0] exp_maddr;
  logic [DW-1:0] exp_msrc;
  int            free_at = 0;
  int            lastg = NC - 1;
  logic [NC-1:0] m_ed, m_elig;
  int            m_g, m_j;

  always @(negedge clk) begin
    m_ed = '0;
    if (armed && !rst) begin
      for (int i = 0; i < NC; i++)
        if (sched_t[i] == cyc) begin
          m_ed[i] = 1'b1;
          if (!sched_we[i]) exp_rd[i] = sched_val[i];
        end
      if (ev_t == cyc) begin
        exp_maddr = ev_addr;
        exp_msrc  = ev_src;
      end
      chk("req_done", 32'(o_done), 32'(m_ed));
      chk("mem_wr", 32'(o_mwr), 32'((ev_t == cyc) && ev_wr));
      chk("mem_addr", o_maddr, exp_maddr);
      chk("mem_src", o_msrc, exp_msrc);
      for (int i = 0; i < NC; i++) chk($sformatf("req_rdata%0d", i), o_rdata[i], exp_rd[i]);
      for (int i = 0; i < NC; i++)
        if (o_done[i] === 1'b1) dlog.push_back('{cyc, i, o_rdata[i]});
    end
    seen_done = o_done;
    prv_addr  = o_maddr;
    prv_wr    = o_mwr;
    prv_src   = o_msrc;
    if (rst) begin
      armed = 1'b1;
      for (int i = 0; i < NC; i++) begin
        sched_t[i] = -1;
        exp_rd[i]  = '0;
      end
      ev_t = -1; exp_maddr = '0; exp_msrc = '0;
      free_at = 0; lastg = NC - 1;
    end else if (armed && free_at <= cyc) begin
      m_elig = vld;
      for (int i = 0; i < NC; i++)
        if (m_ed[i] || sched_t[i] > cyc) m_elig[i] = 1'b0;
      m_g = -1;
      for (int k = 0; k < NC; k++) begin
        m_j = sel ? (lastg + 1 + k) % NC : k;
        if (m_g < 0 && m_elig[m_j]) m_g = m_j;
      end
      if (m_g >= 0) begin
        sched_t[m_g]   = cyc + 3;
        sched_we[m_g]  = we[m_g];
        sched_val[m_g] = we[m_g] ? '0 : ref_read(addr[m_g]);
        if (we[m_g]) ref_mem[addr[m_g]] = wdata[m_g];
        ev_t = cyc + 1; ev_addr = addr[m_g]; ev_src = wdata[m_g]; ev_wr = we[m_g];
        free_at = cyc + 2;
        lastg = m_g;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit auto_on = 1'b0;   // requesters react to done pulses
  bit rnd_on  = 1'b0;   // random new requests / random read-write
  int rereq   = 0;      // after done: 0 drop, 1 always re-request, 2 random

  task automatic new_req(input int i);
    vld[i] = 1'b1;
    if (rnd_on) we[i] = 1'($urandom_range(0, 1));
    addr[i]  = 32'h100 + 32'($urandom_range(0, 7)) * 4;
    wdata[i] = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (prv_wr === 1'b1) mem[prv_addr] = prv_src;
    mdata = mem.exists(prv_addr) ? mem[prv_addr] : init_val(prv_addr);
    if (auto_on)
      for (int i = 0; i < NC; i++) begin
        if (vld[i] && seen_done[i]) begin
          if (rereq == 1 || (rereq == 2 && $urandom_range(0, 1) == 1)) new_req(i);
          else vld[i] = 1'b0;
        end else if (!vld[i] && rnd_on && $urandom_range(0, 3) == 0) begin
          new_req(i);
        end
      end
  endtask

  task automatic do_reset(input logic s);
    auto_on = 1'b0; rnd_on = 1'b0; rereq = 0;
    vld = '0; we = '0;
    sel = s;
    rst = 1'b1;
    mem.delete();
    ref_mem.delete();
    step(); step();
    rst = 1'b0;
    step();
    dlog.delete();
  endtask

  task automatic chk_done(input string nm, input int k, input int ech, input int et,
                          input int t0);
    if (dlog.size() > k) begin
      chk({nm, "_ch"}, dlog[k].ch, ech);
      chk({nm, "_lat"}, dlog[k].t - t0, et);
    end else begin
      chk({nm, "_missing"}, dlog.size(), k + 1);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic          s;     // 0 fixed, 1 round-robin
    logic [NC-1:0] v;     // channels requesting
    logic [NC-1:0] w;     // of those, writes
    int            ch1;   // first done channel
    int            t1;    // its latency from request
    logic [31:0]   d1;    // its req_rdata at done
    int            ch2;   // second done channel
    int            t2;
    int            n;     // total done pulses
  } vec_t;

  vec_t tab [8];
  int   t0;

  initial begin
    // ch0 @0x30000, ch1 @0x100, ch2 @0x30008, ch3 @0x3000C, wdata 0x41+i
    tab[0] = '{1'b0, 4'b0010, 4'b0000, 1, 3, 32'hDEAD_BEEF,        -1, 0, 1};
    tab[1] = '{1'b0, 4'b0001, 4'b0001, 0, 3, 32'h0,                -1, 0, 1};
    tab[2] = '{1'b0, 4'b0101, 4'b0000, 0, 3, init_val(32'h30000),   2, 5, 2};
    tab[3] = '{1'b1, 4'b1010, 4'b0000, 1, 3, 32'hDEAD_BEEF,         3, 5, 2};
    tab[4] = '{1'b0, 4'b1111, 4'b1010, 0, 3, init_val(32'h30000),   1, 5, 4};
    tab[5] = '{1'b1, 4'b1100, 4'b1100, 2, 3, 32'h0,                 3, 5, 2};
    tab[6] = '{1'b0, 4'b1000, 4'b0000, 3, 3, init_val(32'h3000C),  -1, 0, 1};
    tab[7] = '{1'b1, 4'b0001, 4'b0000, 0, 3, init_val(32'h30000),  -1, 0, 1};

    do_reset(1'b0);

    for (int k = 0; k < 8; k++) begin
      do_reset(tab[k].s);
      for (int i = 0; i < NC; i++) begin
        addr[i]  = (i == 1) ? 32'h100 : 32'h30000 + 32'(i) * 4;
        wdata[i] = 32'h41 + 32'(i);
        we[i]    = tab[k].w[i];
        vld[i]   = tab[k].v[i];
      end
      auto_on = 1'b1;
      t0 = cyc;
      repeat (12) step();
      chk_done($sformatf("tab%0d_first", k), 0, tab[k].ch1, tab[k].t1, t0);
      if (dlog.size() > 0) chk($sformatf("tab%0d_rdata", k), dlog[0].d, tab[k].d1);
      if (tab[k].ch2 >= 0) chk_done($sformatf("tab%0d_second", k), 1, tab[k].ch2, tab[k].t2, t0);
      chk($sformatf("tab%0d_count", k), dlog.size(), tab[k].n);
    end

    // round-robin, every channel re-requests right after its done
    do_reset(1'b1);
    for (int i = 0; i < NC; i++) new_req(i);
    auto_on = 1'b1; rereq = 1;
    t0 = cyc;
    repeat (16) step();
    for (int k = 0; k < 6; k++) chk_done($sformatf("rr_order%0d", k), k, k % NC, 3 + 2 * k, t0);
    if (dlog.size() > 4) chk("rr_same_ch_gap", dlog[4].t - dlog[0].t, 8);

    // reset during ISSUE abandons the write; pointer returns to NC-1
    do_reset(1'b1);
    vld[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h30004; wdata[1] = 32'h55;
    auto_on = 1'b1;
    step();                         // ISSUE cycle
    rst = 1'b1; vld = '0;
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("rst_no_done", dlog.size(), 0);
    we = '0; vld[1] = 1'b1; vld[3] = 1'b1;
    t0 = cyc;
    repeat (8) step();
    chk_done("rst_rr_first", 0, 1, 3, t0);
    chk_done("rst_rr_second", 1, 3, 5, t0);

    // same channel back-to-back: new read the cycle after the done pulse
    do_reset(1'b0);
    vld[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h100;
    for (int n = 0; n < 10 && !seen_done[0]; n++) step();
    addr[0] = 32'h200;
    step();
    for (int n = 0; n < 10 && !seen_done[0]; n++) step();
    vld[0] = 1'b0;
    repeat (3) step();
    chk("b2b_count", dlog.size(), 2);
    if (dlog.size() == 2) begin
      chk("b2b_rdata0", dlog[0].d, 32'hDEAD_BEEF);
      chk("b2b_rdata1", dlog[1].d, init_val(32'h200));
      chk("b2b_gap", dlog[1].t - dlog[0].t, 4);
    end

    // random traffic in both modes, checked cycle by cycle by the model
    for (int s = 0; s < 2; s++) begin
      do_reset(1'(s));
      auto_on = 1'b1; rnd_on = 1'b1; rereq = 2;
      repeat (400) step();
      rnd_on = 1'b0; rereq = 0;
      repeat (20) step();
      chk($sformatf("rand%0d_drained", s), 32'(vld), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
